// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// MEM timeout, illegal-opcode trap, halt request and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             J,
  output logic             JC,
  output logic             NEQ,
  output logic             INA,
  output logic             SIN,
  output logic             SOUT,
  output logic             RM,
  output logic             WM,
  output logic             WR,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic illegal_op;
  logic timeout_hit;

  // Any opcode bit above bit 2 marks an instruction this datapath cannot execute.
  assign illegal_op  = |(opcode >> 3);
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    fault_d = fault_q;
    count_d = count_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (illegal_op) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (op_q[2:1] == 2'b01) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        count_d = count_q + CNT_W'(1);
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:   if (!halt_req && !fault_q) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: reset is synchronous here, and all state uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Moore outputs; reset is folded in combinationally so everything reads 0 while it is held.
  always_comb begin
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    J           = 1'b0;
    JC          = 1'b0;
    NEQ         = 1'b0;
    INA         = 1'b0;
    SIN         = 1'b0;
    SOUT        = 1'b0;
    RM          = 1'b0;
    WM          = 1'b0;
    WR          = 1'b0;
    busy        = 1'b0;
    fault       = 1'b0;
    instr_count = '0;
    state_o     = 3'd0;
    if (!reset) begin
      state_o     = state_q;
      busy        = (state_q != S_HALT);
      fault       = fault_q;
      instr_count = count_q;
      ir_load     = (state_q == S_FETCH);
      pc_en       = (state_q == S_WB);
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        unique case (op_q[2:0])
          3'b000:  SOUT = 1'b1;
          3'b001:  begin INA = 1'b1; SIN = 1'b1; end
          3'b100:  J = 1'b1;
          3'b101:  JC = 1'b1;
          3'b111:  begin JC = 1'b1; NEQ = 1'b1; end
          default: ;
        endcase
      end
      RM = (state_q == S_MEM) && (op_q[2:0] == 3'b011);
      WM = (state_q == S_MEM) && (op_q[2:0] == 3'b010);
      WR = (state_q == S_WB)  && (op_q[2:0] == 3'b011 || op_q[2:0] == 3'b110);
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, multi-cycle successor to the 8-bit processor's combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Holds memory strobes until a memory ready handshake, times out on a hung memory, and traps illegal opcodes.
- Supports a halt request and keeps a retired-instruction counter. Drives the same datapath control flags as the single-cycle decoder, now time-qualified.

Parameters:
- OP_W, 3, opcode width. Codes with any bit above bit 2 set are illegal.
- TIMEOUT, 15, maximum MEM wait cycles with mem_ready low before a fault. 0 disables the timeout.
- CNT_W, 16, width of instr_count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OP_W  opcode field of the instruction register, sampled in DECODE
- mem_ready  in  1  data memory completion, sampled in MEM
- halt_req  in  1  request to stop after the current instruction
- ir_load  out  1  load instruction register (FETCH)
- pc_en  out  1  PC update strobe (WB)
- J, JC, NEQ, INA, SIN, SOUT  out  1 each  decoded class flags
- RM, WM  out  1 each  data memory read/write strobes
- WR  out  1  register-file write strobe
- busy  out  1  high when state is not HALT
- fault  out  1  sticky error flag
- instr_count  out  CNT_W  number of retired instructions
- state_o  out  3  debug encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5

Behaviour:
- Reset:
  - While reset is high, all outputs are 0, including busy.
  - State is forced to FETCH; op_q, wait counter, fault and instr_count clear.
  - The first cycle after reset deasserts is FETCH.
- Decode table, applied to op_q[2:0]:
  - 000 R: SOUT
  - 001 MFI: INA, SIN
  - 010 MW: WM
  - 011 MR: RM, WR
  - 100 J: J
  - 101 JCE: JC
  - 110 MB: WR
  - 111 JCN: JC, NEQ
- Outputs are Moore, decoded from state and op_q.
- FETCH: ir_load=1 for one cycle; next state is DECODE.
- DECODE:
  - op_q <= opcode.
  - If opcode[OP_W-1:3] != 0: fault <= 1 and go to HALT. No flags assert and instr_count does not increment.
  - Otherwise go to EXEC.
- EXEC: one cycle. Next state is MEM for MW/MR, else WB.
- Class-flag timing:
  - J, JC, NEQ, INA, SIN, SOUT are held high for every cycle from EXEC through WB inclusive, per the table.
  - RM/WM are high only in MEM.
  - WR is high only in the WB cycle.
- MEM:
  - The strobe holds until mem_ready=1 is sampled, then the next state is WB.
  - The wait counter increments on each MEM cycle with mem_ready=0 and clears on entering MEM.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0: fault <= 1, go to HALT, and the strobe drops the next cycle.
  - mem_ready=1 on the same edge as the timeout compare: ready wins.
- WB:
  - pc_en=1 for one cycle and instr_count increments, wrapping at 2^CNT_W.
  - Next state is HALT if halt_req=1, else FETCH.
- HALT:
  - All strobes and flags are 0, busy=0.
  - Exits to FETCH when halt_req=0 and fault=0. With fault=1, only reset exits.
  - halt_req is ignored outside WB and HALT.
- Latency:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5+N cycles, where N is the number of MEM cycles with mem_ready low.
- Reset asserted mid-instruction (including in MEM) aborts it: no pc_en, no WR, no count increment.

Test Plan:
1. Reset, then opcode=000 with halt_req=0:
   - Expected states: 0,1,2,4,0.
   - SOUT high in cycles 3-4, pc_en pulses once, instr_count=1.
2. opcode=011 with mem_ready low 3 cycles then high:
   - Expected states: FETCH, DECODE, EXEC, MEM×4, WB.
   - RM high for exactly 4 cycles, WR high only in the WB cycle, total 8 cycles.
3. opcode=010 with mem_ready held low and TIMEOUT=15:
   - Expected: after 15 MEM wait cycles, fault=1, state=5, WM=0, busy=0.
   - Releasing halt_req does not exit HALT; reset clears fault.
4. OP_W=4, opcode=1000:
   - Expected: DECODE goes to HALT, fault=1, no flags asserted, instr_count unchanged.
5. halt_req=1 during WB of a J (100):
   - Expected: J high in EXEC and WB, then HALT.
   - After halt_req drops, state goes to FETCH on the next cycle.
6. CNT_W=2, run 5 instructions:
   - Expected instr_count sequence: 1,2,3,0,1.
   - Assert reset in MEM of a 6th instruction (MR): expected outputs 0 and count 0, no WR.
